// File: rtl/dct_coef_serializer.sv
// Captures 4-coefficient DCT frames, quantizes (>>SHIFT, saturating) into a frame FIFO,
// and streams them one coefficient per valid/ready handshake. Build option: DCT_ROUND_EN.

module dct_coef_quant #(
   parameter int IN_W  = 18,
   parameter int OUT_W = 12,
   parameter int SHIFT = 4
) (
   input  logic [IN_W-1:0]  c,
   output logic [OUT_W-1:0] q,
   output logic             sat
);
   localparam logic signed [IN_W:0] MAXV = (IN_W+1)'((2**(OUT_W-1)) - 1);
   localparam logic signed [IN_W:0] MINV = (IN_W+1)'(-(2**(OUT_W-1)));
`ifdef DCT_ROUND_EN
   localparam logic signed [IN_W:0] RND = (IN_W+1)'(2**(SHIFT-1));
`else
   localparam logic signed [IN_W:0] RND = '0;
`endif

   logic signed [IN_W:0] ext, rs;

   // one extra bit of headroom so the rounding add cannot wrap
   always_comb begin
      ext = {c[IN_W-1], c};
      rs  = (ext + RND) >>> SHIFT;
      sat = 1'b0;
      if (rs > MAXV) begin
         q   = MAXV[OUT_W-1:0];
         sat = 1'b1;
      end else if (rs < MINV) begin
         q   = MINV[OUT_W-1:0];
         sat = 1'b1;
      end else begin
         q   = rs[OUT_W-1:0];
      end
   end
endmodule

module dct_coef_serializer #(
   parameter int IN_W  = 18,
   parameter int OUT_W = 12,
   parameter int SHIFT = 4,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  c0,
   input  logic [IN_W-1:0]  c1,
   input  logic [IN_W-1:0]  c2,
   input  logic [IN_W-1:0]  c3,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic [1:0]       out_idx,
   output logic             out_last,
   output logic             sat_flag
);
   localparam int NUM_LANES = 4;
   localparam int AW = $clog2(DEPTH);

   typedef enum logic {IDLE, SEND} state_t;

   state_t                           state;
   logic [NUM_LANES-1:0][IN_W-1:0]   cin;
   logic [NUM_LANES-1:0][OUT_W-1:0]  q;
   logic [NUM_LANES-1:0]             sat;
   logic [OUT_W-1:0]                 mem [DEPTH][NUM_LANES];
   logic [AW-1:0]                    wr_ptr, rd_ptr;
   logic [AW:0]                      count, count_next;
   logic                             push, fire, pop;

   assign cin = {c3, c2, c1, c0};

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      dct_coef_quant #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT)) u_quant (
         .c   (cin[i]),
         .q   (q[i]),
         .sat (sat[i])
      );
   end

   assign in_ready = (count < (AW+1)'(DEPTH));
   assign push     = in_valid & in_ready;
   assign fire     = out_valid & out_ready;
   assign pop      = fire & (out_idx == 2'd3);
   assign out_last = (out_idx == 2'd3);
   // head is read straight from storage, so a frame written on the popping edge is visible at once
   assign out_data = out_valid ? mem[rd_ptr][out_idx] : '0;

   always_comb begin
      count_next = count;
      if (push && !pop)
         count_next = count + 1'b1;
      else if (pop && !push)
         count_next = count - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (push)
         for (int i = 0; i < NUM_LANES; i++)
            mem[wr_ptr][i] <= q[i];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         out_valid <= 1'b0;
         out_idx   <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         sat_flag  <= 1'b0;
      end else begin
         count <= count_next;
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (|sat)
               sat_flag <= 1'b1;
         end
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         case (state)
            IDLE: begin
               if (count != '0) begin
                  state     <= SEND;
                  out_valid <= 1'b1;
               end
            end
            SEND: begin
               if (fire) begin
                  out_idx <= out_idx + 1'b1;
                  if (out_idx == 2'd3 && count_next == '0) begin
                     state     <= IDLE;
                     out_valid <= 1'b0;
                  end
               end
            end
            default: begin
               state     <= IDLE;
               out_valid <= 1'b0;
            end
         endcase
      end
   end
endmodule
